// File: rtl/operand_stream_sequencer_pkg.sv
// Shared types and sizing helpers for the operand stream sequencer.
// Byte counts come from log2 parameters. Index widths never drop below 1 bit.
package operand_stream_sequencer_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EXEC   = 2'd1,
    UNLOAD = 2'd2
  } seq_state_e;

  // EXEC_CYCLES is limited to 1..15, so 4 bits are enough for the counter.
  localparam int EXEC_CNT_W = 4;

  function automatic int bytes_from_log2(input int log2_bytes);
    return 1 << log2_bytes;
  endfunction

  function automatic int idx_width(input int log2_bytes);
    return (log2_bytes > 0) ? log2_bytes : 1;
  endfunction

endpackage

// File: rtl/operand_stream_sequencer_byte_deserializer.sv
// Auto-indexed byte-write register. It accepts one byte per valid/ready handshake.
// It strobes done on the write that fills the last byte. clear rewinds the index but keeps the word.
module byte_deserializer
  import operand_stream_sequencer_pkg::*;
#(
  parameter  int LOG2_BYTES = 3,
  localparam int NB         = bytes_from_log2(LOG2_BYTES),
  localparam int IW         = idx_width(LOG2_BYTES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [NB*8-1:0] word,
  output logic [IW-1:0]   idx,
  output logic            done
);

  logic [IW-1:0]   idx_reg;
  logic [NB*8-1:0] word_reg;
  logic            wr_en;

  assign in_ready = enable;
  // A clear in the same cycle drops the byte instead of writing it.
  assign wr_en    = enable && in_valid && !clear;
  assign done     = wr_en && (idx_reg == IW'(NB - 1));
  assign word     = word_reg;
  assign idx      = idx_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_reg <= '0;
    end else if (wr_en) begin
      idx_reg <= done ? '0 : idx_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    always_ff @(posedge clk) begin
      if (rst) begin
        word_reg[gi*8 +: 8] <= 8'h00;
      end else if (wr_en && idx_reg == IW'(gi)) begin
        word_reg[gi*8 +: 8] <= in_data;
      end
    end
  end

endmodule

// File: rtl/operand_stream_sequencer.sv
// Byte-serial front end for the two-operand datapath. It assembles x and y from an input stream,
// pulses op_start, waits EXEC_CYCLES, captures res_data and streams the result bytes out LSB first.
module operand_stream_sequencer
  import operand_stream_sequencer_pkg::*;
#(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2,
  parameter int EXEC_CYCLES    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [7:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            flush,
  output logic [(4<<LOG2_BYTES_IN)-1:0]   op_x,
  output logic [(4<<LOG2_BYTES_IN)-1:0]   op_y,
  output logic                            op_start,
  input  logic [(8<<LOG2_BYTES_OUT)-1:0]  res_data,
  output logic                            busy
);

  localparam int BYTES_IN  = bytes_from_log2(LOG2_BYTES_IN);
  localparam int BYTES_OUT = bytes_from_log2(LOG2_BYTES_OUT);
  localparam int IN_IW     = idx_width(LOG2_BYTES_IN);
  localparam int OUT_IW    = idx_width(LOG2_BYTES_OUT);

  seq_state_e                state_reg, state_next;
  logic [EXEC_CNT_W-1:0]     exec_cnt_reg, exec_cnt_next;
  logic [OUT_IW-1:0]         out_idx_reg, out_idx_next;
  logic [BYTES_OUT*8-1:0]    result_reg;
  logic                      capture;
  logic [BYTES_IN*8-1:0]     operand;
  logic [IN_IW-1:0]          in_idx;
  logic                      load_done;
  logic [7:0]                res_bytes [BYTES_OUT];

  byte_deserializer #(
    .LOG2_BYTES (LOG2_BYTES_IN)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .enable   (state_reg == LOAD),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .word     (operand),
    .idx      (in_idx),
    .done     (load_done)
  );

  assign op_x = operand[BYTES_IN*4-1:0];
  assign op_y = operand[BYTES_IN*8-1:BYTES_IN*4];

  for (genvar gi = 0; gi < BYTES_OUT; gi++) begin : g_res_byte
    assign res_bytes[gi] = result_reg[gi*8 +: 8];
  end

  assign out_data = res_bytes[out_idx_reg];
  assign busy     = (state_reg != LOAD) || (in_idx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LOAD;
      exec_cnt_reg <= '0;
      out_idx_reg  <= '0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      exec_cnt_reg <= exec_cnt_next;
      out_idx_reg  <= out_idx_next;
      if (capture) begin
        result_reg <= res_data;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    exec_cnt_next = exec_cnt_reg;
    out_idx_next  = out_idx_reg;
    capture       = 1'b0;
    op_start      = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      LOAD: begin
        if (load_done) begin
          state_next    = EXEC;
          exec_cnt_next = EXEC_CNT_W'(EXEC_CYCLES);
        end
      end
      EXEC: begin
        // The counter still holds its load value only in the first EXEC cycle.
        op_start      = (exec_cnt_reg == EXEC_CNT_W'(EXEC_CYCLES));
        exec_cnt_next = exec_cnt_reg - 1'b1;
        if (exec_cnt_reg == EXEC_CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_idx_reg == OUT_IW'(BYTES_OUT - 1)) begin
            out_idx_next = '0;
            state_next   = LOAD;
          end else begin
            out_idx_next = out_idx_reg + 1'b1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
    // flush aborts the operation but keeps the operand and result registers.
    if (flush) begin
      state_next    = LOAD;
      exec_cnt_next = '0;
      out_idx_next  = '0;
      capture       = 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_stream_sequencer.sv
// Directed bench for operand_stream_sequencer. The adder datapath is modelled as op_x + op_y.
// A second instance with EXEC_CYCLES=3 covers execution latency and reset during EXEC.
module tb_operand_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [7:0]  in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready, op_start, busy;
  logic [31:0] op_x, op_y, res_data;

  logic        rst2;
  logic [7:0]  in_data2, out_data2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, op_start2, busy2;
  logic [31:0] op_x2, op_y2, res_data2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign res_data  = op_x + op_y;
  assign res_data2 = op_x2 + op_y2;

  operand_stream_sequencer #(
    .LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .EXEC_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .op_x(op_x), .op_y(op_y), .op_start(op_start), .res_data(res_data), .busy(busy)
  );

  operand_stream_sequencer #(
    .LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .EXEC_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .flush(1'b0),
    .op_x(op_x2), .op_y(op_y2), .op_start(op_start2), .res_data(res_data2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // All tasks begin and end at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("in  byte %02h", b);
  endtask

  task automatic send_op(input logic [63:0] word);
    for (int i = 0; i < 8; i++) send_byte(word[i*8 +: 8]);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int k = 0;
    out_ready = 1'b1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("recv_timeout", {31'd0, out_valid}, 32'd1);
    check(tag, {24'd0, out_data}, {24'd0, exp});
    $display("out byte %02h", out_data);
    @(negedge clk);
  endtask

  task automatic recv_word(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) recv_byte(tag, exp[i*8 +: 8]);
  endtask

  initial begin
    logic [63:0] op_word;
    rst = 1'b1; rst2 = 1'b1; flush = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    in_data2 = 8'h00; in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // Reset state
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_op_start",  {31'd0, op_start},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_op_x",      op_x,               32'd0);
    check("rst_op_y",      op_y,               32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);

    // Scenario 1: basic add, op_start one cycle after the last input byte
    send_op(64'h00000001_12345678);
    check("s1_op_start", {31'd0, op_start}, 32'd1);
    check("s1_op_x", op_x, 32'h12345678);
    check("s1_op_y", op_y, 32'h00000001);
    recv_word("s1_out", 32'h12345679);
    check("s1_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("s1_busy_after",     {31'd0, busy},     32'd0);

    // Scenario 2: carry-out is lost; busy window
    send_byte(8'hFF);
    check("s2_busy_first", {31'd0, busy}, 32'd1);
    op_word = 64'h00000001_FFFFFFFF;
    for (int i = 1; i < 8; i++) send_byte(op_word[i*8 +: 8]);
    for (int i = 0; i < 4; i++) begin
      check("s2_busy_unload", {31'd0, busy}, 32'd1);
      recv_byte("s2_out", 8'h00);
    end
    check("s2_busy_done", {31'd0, busy}, 32'd0);

    // Scenario 3: backpressure on byte 2
    send_op(64'h00000001_12345678);
    recv_byte("s3_out0", 8'h79);
    recv_byte("s3_out1", 8'h56);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("s3_hold_data",  {24'd0, out_data},  32'h34);
      @(negedge clk);
    end
    recv_byte("s3_out2", 8'h34);
    recv_byte("s3_out3", 8'h12);
    check("s3_no_extra", {31'd0, out_valid}, 32'd0);

    // Scenario 4: flush after five bytes discards the partial operand
    for (int i = 0; i < 5; i++) send_byte(8'hEE);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("s4_busy_flushed", {31'd0, busy}, 32'd0);
    send_op(64'h00000002_00000001);
    check("s4_op_x", op_x, 32'h00000001);
    check("s4_op_y", op_y, 32'h00000002);
    recv_word("s4_out", 32'h00000003);

    // Scenario 5: in_valid held through EXEC/UNLOAD is not consumed
    send_op(64'h00000006_00000005);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s5_in_ready_low", {31'd0, in_ready}, 32'd0);
      recv_byte("s5_out", (i == 0) ? 8'h0B : 8'h00);
    end
    check("s5_idle_busy",  {31'd0, busy},     32'd0);
    check("s5_in_ready",   {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("s5_consumed", {31'd0, busy}, 32'd1);
    op_word = 64'h00000001_000000AA;
    for (int i = 1; i < 8; i++) send_byte(op_word[i*8 +: 8]);
    recv_word("s5_next_out", 32'h000000AB);

    // Scenario 6a: EXEC_CYCLES=3 latency from op_start to out_valid
    op_word = 64'h00000004_00000003;
    in_valid2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data2 = op_word[i*8 +: 8];
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    check("s6_op_start", {31'd0, op_start2}, 32'd1);
    check("s6_valid_c0", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("s6_op_start_once", {31'd0, op_start2}, 32'd0);
    check("s6_valid_c1", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("s6_valid_c2", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("s6_valid_c3", {31'd0, out_valid2}, 32'd1);
    out_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s6_out", {24'd0, out_data2}, (i == 0) ? 32'h07 : 32'h00);
      $display("out byte %02h (exec3)", out_data2);
      @(negedge clk);
    end
    check("s6_back_to_load", {31'd0, in_ready2}, 32'd1);

    // Scenario 6b: reset in the second EXEC cycle
    op_word = 64'h00000010_00000020;
    in_valid2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data2 = op_word[i*8 +: 8];
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    check("s6r_in_ready",  {31'd0, in_ready2},  32'd1);
    check("s6r_op_start",  {31'd0, op_start2},  32'd0);
    check("s6r_out_valid", {31'd0, out_valid2}, 32'd0);
    check("s6r_busy",      {31'd0, busy2},      32'd0);
    check("s6r_op_x",      op_x2,               32'd0);
    for (int i = 0; i < 6; i++) begin
      check("s6r_no_output", {31'd0, out_valid2}, 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_stream_sequencer.md
Name: operand_stream_sequencer

Overview:
- Byte-serial front end for the two-operand datapath; the datapath is the ripple adder with x = low half and y = high half of the operand word.
- Accepts operand bytes over a valid/ready stream and assembles x and y.
- Issues a start pulse, waits a fixed number of execution cycles, captures the result, then streams result bytes out with backpressure.
- Replaces manual per-byte select addressing with an auto-indexed handshake so one pin group can feed the datapath continuously.

Parameters:
- LOG2_BYTES_IN, 3, log2 of operand bytes per operation; x and y are each BYTES_IN*4 bits.
- LOG2_BYTES_OUT, 2, log2 of result bytes per operation.
- EXEC_CYCLES, 1, cycles from op_start to result capture; legal range 1..15.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- flush  in  1  synchronous abort; discards the operation in progress.
- op_x  out  BYTES_IN*4  datapath operand x.
- op_y  out  BYTES_IN*4  datapath operand y.
- op_start  out  1  one-cycle pulse marking operand valid.
- res_data  in  BYTES_OUT*8  datapath result.
- busy  out  1  high in any state other than LOAD, or when the LOAD byte index is nonzero.

Behaviour:
- States: LOAD, EXEC, UNLOAD.
- Reset values: state=LOAD, in_idx=0, out_idx=0, exec_cnt=0, operand register=0, result register=0.
- Reset output values: in_ready=1, out_valid=0, op_start=0, busy=0, op_x=op_y=0, out_data=0.
- LOAD:
  - in_ready=1. A transfer occurs when in_valid and in_ready are both high.
  - On a transfer, write byte in_idx into bits [8*in_idx+7 : 8*in_idx] of the operand word; byte 0 is the LSB of x.
  - x = operand[BYTES_IN*4-1:0]; y = operand[BYTES_IN*8-1:BYTES_IN*4].
  - in_idx increments on each transfer.
  - When the transfer hits in_idx = BYTES_IN-1: in_idx wraps to 0, next state is EXEC, exec_cnt loads EXEC_CYCLES.
- EXEC:
  - in_ready=0. op_start=1 only in the first EXEC cycle.
  - exec_cnt decrements each cycle. In the cycle where exec_cnt==1, res_data is sampled into the result register and the next state is UNLOAD.
  - Last input transfer at edge T: op_start is high in cycle T..T+1, and the result is captured at edge T+EXEC_CYCLES.
- op_x/op_y are driven straight from the operand register. They are stable throughout EXEC and change only on LOAD transfers.
- UNLOAD:
  - in_ready=0, out_valid=1, out_data = result byte out_idx; byte 0 (LSB) goes first.
  - out_idx increments on each out_valid and out_ready handshake.
  - On the handshake at out_idx = BYTES_OUT-1: out_idx wraps to 0, next state is LOAD.
  - Earliest next-operation byte is accepted the cycle after the last output byte; there is no overlap.
- out_valid must not drop, and out_data must not change, while out_ready=0.
- Arithmetic: no width conversion. The result is taken as delivered, so datapath overflow/carry-out is not visible here.
- flush:
  - Same effect as rst on state, in_idx, out_idx, exec_cnt and handshake outputs. Operand and result registers are retained.
  - Takes priority over a simultaneous in or out handshake; that byte is dropped.
- rst has priority over flush. Reset mid-operation discards all partial bytes and takes effect at the next edge.
- in_valid in EXEC or UNLOAD is ignored and the byte is not consumed. The upstream must hold it.

Decomposition:
- Shared package: state enum (LOAD, EXEC, UNLOAD), BYTES_IN/BYTES_OUT derivation from log2 parameters, EXEC_CYCLES width constant.
- One natural sub-module, byte_deserializer: indexed byte-write register with valid/ready and wrap-to-done strobe.
- Output byte mux and FSM stay in the top.

Test Plan (defaults, 32-bit x/y):
- Bytes 78 56 34 12 01 00 00 00, out_ready=1 -> op_start one cycle after the 8th byte; op_x=0x12345678, op_y=0x00000001; out 79 56 34 12; then in_ready=1.
- Inputs FF FF FF FF 01 00 00 00 -> out 00 00 00 00; busy high from the 1st byte until the cycle after the 4th output byte.
- Same as scenario 1 with out_ready low for 3 cycles on byte 2 -> out_data holds 34 with out_valid=1 for those cycles; total 4 bytes, no duplicates.
- flush asserted after 5 input bytes, then a full new operand 01 00 00 00 02 00 00 00 -> out 03 00 00 00; stale bytes are not used.
- in_valid held high continuously during EXEC/UNLOAD -> no byte consumed until back in LOAD; in_ready is 0 in those states.
- EXEC_CYCLES=3, rst asserted in the 2nd EXEC cycle -> next cycle state=LOAD, op_start=0, out_valid=0, no output bytes emitted.
